// File: rtl/branch_redirect_ctrl.sv
// Branch redirect sequencer: computes the taken target in EX, issues a registered PC redirect to IF,
// flushes IF/ID and ID/EX and holds EX until IF accepts. Define BRANCH_PERF_EN to add perf counters.
module branch_redirect_ctrl #(
    parameter int XLEN   = 32,
    parameter int PERF_W = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            ex_valid,
    input  logic            ex_stall,
    input  logic            ex_is_branch,
    input  logic [3:0]      ex_branch_type,
    input  logic [XLEN-1:0] ex_pc,
    input  logic [XLEN-1:0] ex_imm,
    input  logic [XLEN-1:0] ex_rs1,
    input  logic            fetch_ready,
    output logic            redirect_valid,
    output logic [XLEN-1:0] redirect_pc,
    output logic            flush_if_id,
    output logic            flush_id_ex,
    output logic            ex_hold,
    output logic            misalign_exc,
    output logic [XLEN-1:0] misalign_addr
`ifdef BRANCH_PERF_EN
    ,
    output logic [PERF_W-1:0] perf_branches,
    output logic [PERF_W-1:0] perf_redirects
`endif
);

    // state    | meaning
    // IDLE     | watching EX for a taken control transfer
    // REDIRECT | redirect presented to IF, front end flushed, EX held until fetch_ready
    localparam logic [0:0] ST_IDLE     = 1'b0;
    localparam logic [0:0] ST_REDIRECT = 1'b1;

    logic [0:0]      state;
    logic            br_jal;
    logic            br_jalr;
    logic            br_btype;
    logic            taken;
    logic            aligned;
    logic [XLEN-1:0] target;
    logic            unused_auipc;

    assign br_jal   = ex_branch_type[2];
    assign br_jalr  = ex_branch_type[1];
    assign br_btype = ex_branch_type[0];

    // auipc shares the resolver vector but never changes control flow
    assign unused_auipc = ex_branch_type[3];

    assign taken = ex_valid & ~ex_stall & (br_jal | br_jalr | br_btype);

    always_comb begin
        target = ex_pc + ex_imm;
        if (br_jalr) begin
            target = (ex_rs1 + ex_imm) & {{(XLEN-1){1'b1}}, 1'b0};
        end
    end

    assign aligned = (target[1:0] == 2'b00);

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= ST_IDLE;
            redirect_pc   <= '0;
            misalign_exc  <= 1'b0;
            misalign_addr <= '0;
        end else begin
            misalign_exc <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (taken) begin
                        if (aligned) begin
                            state       <= ST_REDIRECT;
                            redirect_pc <= target;
                        end else begin
                            misalign_exc  <= 1'b1;
                            misalign_addr <= target;
                        end
                    end
                end
                ST_REDIRECT: begin
                    // EX content is wrong-path here, so only the IF handshake matters
                    if (fetch_ready) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // All four control outputs are the state flop itself, hence registered and glitch-free
    assign redirect_valid = (state == ST_REDIRECT);
    assign flush_if_id    = (state == ST_REDIRECT);
    assign flush_id_ex    = (state == ST_REDIRECT);
    assign ex_hold        = (state == ST_REDIRECT);

`ifdef BRANCH_PERF_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_branches  <= '0;
            perf_redirects <= '0;
        end else if (state == ST_IDLE) begin
            if (ex_valid & ~ex_stall & ex_is_branch) begin
                perf_branches <= perf_branches + 1'b1;
            end
            if (taken & aligned) begin
                perf_redirects <= perf_redirects + 1'b1;
            end
        end
    end
`else
    logic [PERF_W-1:0] unused_perf;
    assign unused_perf = {PERF_W{ex_is_branch}};
`endif

endmodule

// File: tb/tb_branch_redirect_ctrl.sv
// Self-checking bench for branch_redirect_ctrl: directed scenarios followed by random traffic
// compared cycle by cycle against a queue-based reference model.
module tb_branch_redirect_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        ex_valid;
    logic        ex_stall;
    logic        ex_is_branch;
    logic [3:0]  ex_branch_type;
    logic [31:0] ex_pc;
    logic [31:0] ex_imm;
    logic [31:0] ex_rs1;
    logic        fetch_ready;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        flush_if_id;
    logic        flush_id_ex;
    logic        ex_hold;
    logic        misalign_exc;
    logic [31:0] misalign_addr;
`ifdef BRANCH_PERF_EN
    logic [31:0] perf_branches;
    logic [31:0] perf_redirects;
`endif

    branch_redirect_ctrl #(.XLEN(32), .PERF_W(32)) dut (
        .clk            (clk),
        .rst            (rst),
        .ex_valid       (ex_valid),
        .ex_stall       (ex_stall),
        .ex_is_branch   (ex_is_branch),
        .ex_branch_type (ex_branch_type),
        .ex_pc          (ex_pc),
        .ex_imm         (ex_imm),
        .ex_rs1         (ex_rs1),
        .fetch_ready    (fetch_ready),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .flush_if_id    (flush_if_id),
        .flush_id_ex    (flush_id_ex),
        .ex_hold        (ex_hold),
        .misalign_exc   (misalign_exc),
        .misalign_addr  (misalign_addr)
`ifdef BRANCH_PERF_EN
        ,
        .perf_branches  (perf_branches),
        .perf_redirects (perf_redirects)
`endif
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: a redirect is a queued target address awaiting IF acceptance (depth <= 1)
    logic [31:0] pend_q[$];
    logic        exp_mis;
    logic [31:0] exp_maddr;
    logic [31:0] exp_pbr;
    logic [31:0] exp_prd;
    logic        after_rst;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_step();
        logic [31:0] tgt;
        logic        tk;
        after_rst = rst;
        if (rst) begin
            pend_q.delete();
            exp_mis   = 1'b0;
            exp_maddr = 32'h0;
            exp_pbr   = 32'h0;
            exp_prd   = 32'h0;
        end else begin
            exp_mis = 1'b0;
            if (pend_q.size() == 0) begin
                if (ex_valid && !ex_stall && ex_is_branch) exp_pbr = exp_pbr + 1;
                tk = ex_valid && !ex_stall && (ex_branch_type[2:0] != 3'b000);
                if (ex_branch_type[1]) tgt = ((ex_rs1 + ex_imm) / 2) * 2;
                else                   tgt = ex_pc + ex_imm;
                if (tk) begin
                    if (tgt % 4 == 0) begin
                        pend_q.push_back(tgt);
                        exp_prd = exp_prd + 1;
                    end else begin
                        exp_mis   = 1'b1;
                        exp_maddr = tgt;
                    end
                end
            end else if (fetch_ready) begin
                void'(pend_q.pop_front());
            end
        end
    endtask

    task automatic check_outputs();
        logic busy;
        busy = (pend_q.size() != 0);
        check_val("redirect_valid", 32'(redirect_valid), 32'(busy));
        check_val("flush_if_id",    32'(flush_if_id),    32'(busy));
        check_val("flush_id_ex",    32'(flush_id_ex),    32'(busy));
        check_val("ex_hold",        32'(ex_hold),        32'(busy));
        check_val("misalign_exc",   32'(misalign_exc),   32'(exp_mis));
        if (busy)      check_val("redirect_pc", redirect_pc, pend_q[0]);
        if (exp_mis)   check_val("misalign_addr", misalign_addr, exp_maddr);
        if (after_rst) begin
            check_val("rst_redirect_pc", redirect_pc, 32'h0);
            check_val("rst_misalign_addr", misalign_addr, 32'h0);
        end
`ifdef BRANCH_PERF_EN
        check_val("perf_branches",  perf_branches,  exp_pbr);
        check_val("perf_redirects", perf_redirects, exp_prd);
`endif
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        #1;
        check_outputs();
    endtask

    task automatic quiet();
        rst            = 1'b0;
        ex_valid       = 1'b0;
        ex_stall       = 1'b0;
        ex_is_branch   = 1'b0;
        ex_branch_type = 4'b0000;
        ex_pc          = 32'h0;
        ex_imm         = 32'h0;
        ex_rs1         = 32'h0;
        fetch_ready    = 1'b1;
    endtask

    task automatic branch(input logic [3:0] bt, input logic [31:0] pc, input logic [31:0] imm,
                          input logic [31:0] rs1);
        ex_valid       = 1'b1;
        ex_is_branch   = 1'b1;
        ex_branch_type = bt;
        ex_pc          = pc;
        ex_imm         = imm;
        ex_rs1         = rs1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cycle();
        rst = 1'b0;
    endtask

    initial begin
        quiet();
        do_reset();
        check_val("reset_valid", 32'(redirect_valid), 32'h0);

        // 1: jal, immediate acceptance
        branch(4'b0100, 32'h100, 32'h40, 32'h0);
        fetch_ready = 1'b1;
        cycle();
        check_val("t1_pc", redirect_pc, 32'h140);
        check_val("t1_valid", 32'(redirect_valid), 32'h1);
        quiet();
        cycle();
        check_val("t1_release", 32'(redirect_valid), 32'h0);

        // 2: jalr with three cycles of back-pressure
        branch(4'b0010, 32'h0, 32'h3, 32'h2001);
        cycle();
        quiet();
        fetch_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            branch(4'b0100, 32'h500, 32'h8, 32'h0);  // wrong-path, must be ignored
            cycle();
            check_val("t2_pc", redirect_pc, 32'h2004);
        end
        quiet();
        fetch_ready = 1'b1;
        cycle();
        check_val("t2_pc_last", redirect_pc, 32'h2004);
        cycle();
        check_val("t2_release", 32'(ex_hold), 32'h0);

        // 3: auipc only
        branch(4'b1000, 32'h100, 32'h40, 32'h0);
        cycle();
        check_val("t3_valid", 32'(redirect_valid), 32'h0);
        quiet();
        cycle();

        // 4: misaligned jal
        branch(4'b0100, 32'h100, 32'h2, 32'h0);
        cycle();
        check_val("t4_exc", 32'(misalign_exc), 32'h1);
        check_val("t4_addr", misalign_addr, 32'h102);
        quiet();
        cycle();
        check_val("t4_pulse", 32'(misalign_exc), 32'h0);

        // 5: reset in the second REDIRECT cycle
        branch(4'b0100, 32'h200, 32'h20, 32'h0);
        fetch_ready = 1'b0;
        cycle();
        quiet();
        fetch_ready = 1'b0;
        cycle();
        rst = 1'b1;
        cycle();
        check_val("t5_valid", 32'(redirect_valid), 32'h0);
        rst = 1'b0;
        fetch_ready = 1'b1;
        branch(4'b0100, 32'h300, 32'h10, 32'h0);
        cycle();
        check_val("t5_pc", redirect_pc, 32'h310);
        quiet();
        cycle();

        // 6: stalled jal, then released
        do_reset();
        branch(4'b0100, 32'h400, 32'h80, 32'h0);
        ex_stall = 1'b1;
        cycle();
        check_val("t6_stall", 32'(redirect_valid), 32'h0);
        ex_stall = 1'b0;
        cycle();
        check_val("t6_pc", redirect_pc, 32'h480);
`ifdef BRANCH_PERF_EN
        check_val("t6_pbr", perf_branches, 32'h1);
        check_val("t6_prd", perf_redirects, 32'h1);
`endif
        quiet();
        cycle();

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            rst            = ($urandom_range(99) < 2);
            ex_valid       = ($urandom_range(99) < 75);
            ex_stall       = ($urandom_range(99) < 20);
            ex_branch_type = 4'($urandom);
            ex_is_branch   = ($urandom_range(9) < 8) ? (ex_branch_type[2:0] != 3'b000) : 1'($urandom);
            ex_pc          = $urandom & 32'hFFFF_FFFC;
            ex_imm         = ($urandom_range(9) < 7) ? ($urandom & 32'hFFFF_FFFC) : $urandom;
            ex_rs1         = $urandom;
            fetch_ready    = ($urandom_range(99) < 50);
            cycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
